// File: rtl/requant_pack.sv
// Output stage of the KWS accelerator: bias add, TFLite-style fixed-point requantization,
// output offset and clamp, then packing of four int8 results into one 32-bit word.
module requant_pack (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [31:0] cfg_out_offset,
    input  logic [31:0] cfg_act_min,
    input  logic [31:0] cfg_act_max,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic [31:0] in_bias,
    input  logic [31:0] in_mult,
    input  logic [5:0]  in_shift,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_count
);

    logic signed [31:0] r_out_offset;
    logic signed [31:0] r_act_min;
    logic signed [31:0] r_act_max;

    logic               r_s1_valid;
    logic signed [31:0] r_s1_x;
    logic signed [31:0] r_s1_mult;
    logic [4:0]         r_s1_rsh;
    logic               r_s1_flush;

    logic               r_s2_valid;
    logic signed [31:0] r_s2_r;
    logic [4:0]         r_s2_rsh;
    logic               r_s2_flush;

    logic               r_s3_valid;
    logic [7:0]         r_s3_byte;
    logic               r_s3_flush;

    logic [31:0]        r_lanes;
    logic [1:0]         r_lane_cnt;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [2:0]         r_out_count;

    logic               w_stall;
    logic [31:0]        w_sum;
    logic [5:0]         w_neg_shift;
    logic [4:0]         w_lsh;
    logic [4:0]         w_rsh;
    logic [31:0]        w_x;
    logic signed [63:0] w_ab;
    logic signed [63:0] w_ab_nudged;
    logic signed [63:0] w_ab_div;
    logic signed [31:0] w_srdhm;
    logic [31:0]        w_mask;
    logic [31:0]        w_rem;
    logic [31:0]        w_thr;
    logic signed [31:0] w_q;
    logic signed [31:0] w_y;
    logic [7:0]         w_byte;
    logic [31:0]        w_packed;
    logic               w_word_done;
    logic               w_unused_bits;

    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // Stage 1 arithmetic: bias add and left shift, both wrapping at 32 bits.
    always_comb begin
        w_sum       = in_acc + in_bias;
        w_neg_shift = 6'd0 - in_shift;
        w_lsh       = in_shift[5] ? 5'd0 : in_shift[4:0];
        w_rsh       = in_shift[5] ? w_neg_shift[4:0] : 5'd0;
        w_x         = w_sum << w_lsh;
    end

    // Stage 2 arithmetic: saturating rounding doubling high multiply.
    always_comb begin
        w_ab        = r_s1_x * r_s1_mult;
        w_ab_nudged = w_ab + ((w_ab >= 64'sd0) ? 64'sd1073741824 : -64'sd1073741823);
        w_ab_div    = (w_ab_nudged < 64'sd0) ? ((w_ab_nudged + 64'sd2147483647) >>> 31)
                                             : (w_ab_nudged >>> 31);
        if (r_s1_x == 32'sh80000000 && r_s1_mult == 32'sh80000000)
            w_srdhm = 32'sh7FFFFFFF;
        else
            w_srdhm = w_ab_div[31:0];
    end

    assign w_unused_bits = ^{w_ab_div[63:32], w_neg_shift[5]};

    // Stage 3 arithmetic: round-half-away right shift, offset, clamp to activation range.
    always_comb begin
        w_mask = (32'd1 << r_s2_rsh) - 32'd1;
        w_rem  = r_s2_r & w_mask;
        w_thr  = (w_mask >> 1) + {31'd0, r_s2_r[31]};
        w_q    = (r_s2_r >>> r_s2_rsh) + ((w_rem > w_thr) ? 32'sd1 : 32'sd0);
        w_y    = w_q + r_out_offset;
        if (w_y < r_act_min)
            w_byte = r_act_min[7:0];
        else if (w_y > r_act_max)
            w_byte = r_act_max[7:0];
        else
            w_byte = w_y[7:0];
    end

    always_comb begin
        w_packed    = r_lanes | ({24'd0, r_s3_byte} << {r_lane_cnt, 3'b000});
        w_word_done = (r_lane_cnt == 2'd3) | r_s3_flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_offset <= 32'sd0;
            r_act_min    <= -32'sd128;
            r_act_max    <= 32'sd127;
        end else if (cfg_we) begin
            r_out_offset <= cfg_out_offset;
            r_act_min    <= cfg_act_min;
            r_act_max    <= cfg_act_max;
        end
    end

    // The three arithmetic stages advance together and freeze as a unit while the output word is refused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= 32'sd0;
            r_s1_mult  <= 32'sd0;
            r_s1_rsh   <= 5'd0;
            r_s1_flush <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_r     <= 32'sd0;
            r_s2_rsh   <= 5'd0;
            r_s2_flush <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_byte  <= 8'd0;
            r_s3_flush <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            r_s1_x     <= w_x;
            r_s1_mult  <= in_mult;
            r_s1_rsh   <= w_rsh;
            r_s1_flush <= in_flush;
            r_s2_valid <= r_s1_valid;
            r_s2_r     <= w_srdhm;
            r_s2_rsh   <= r_s1_rsh;
            r_s2_flush <= r_s1_flush;
            r_s3_valid <= r_s2_valid;
            r_s3_byte  <= w_byte;
            r_s3_flush <= r_s2_flush;
        end
    end

    // Packer: a completing byte goes straight into the output register, so a handoff and the next word never bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lanes     <= 32'd0;
            r_lane_cnt  <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_count <= 3'd0;
        end else if (!w_stall) begin
            if (r_s3_valid && w_word_done) begin
                r_out_data  <= w_packed;
                r_out_count <= {1'b0, r_lane_cnt} + 3'd1;
                r_out_valid <= 1'b1;
                r_lanes     <= 32'd0;
                r_lane_cnt  <= 2'd0;
            end else begin
                r_out_valid <= 1'b0;
                if (r_s3_valid) begin
                    r_lanes    <= w_packed;
                    r_lane_cnt <= r_lane_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_requant_pack.sv
// Scoreboard bench for requant_pack: directed elements with hand-computed packed words,
// checked by an independent monitor at each output handoff.
module tb_requant_pack;

    logic        clk;
    logic        reset_n;
    logic        cfg_we;
    logic [31:0] cfg_out_offset;
    logic [31:0] cfg_act_min;
    logic [31:0] cfg_act_max;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [31:0] in_bias;
    logic [31:0] in_mult;
    logic [5:0]  in_shift;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    int          checks;
    int          errors;
    int          wordsSeen;
    logic [34:0] expQ[$];

    requant_pack dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_we         (cfg_we),
        .cfg_out_offset (cfg_out_offset),
        .cfg_act_min    (cfg_act_min),
        .cfg_act_max    (cfg_act_max),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_acc         (in_acc),
        .in_bias        (in_bias),
        .in_mult        (in_mult),
        .in_shift       (in_shift),
        .in_flush       (in_flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [31:0] data, input logic [2:0] count);
        expQ.push_back({count, data});
    endtask

    task automatic applyConfig(input logic [31:0] offset, input logic [31:0] amin, input logic [31:0] amax);
        cfg_out_offset = offset;
        cfg_act_min    = amin;
        cfg_act_max    = amax;
        cfg_we         = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] acc, input logic [31:0] bias, input logic [31:0] mult,
                                 input logic [5:0] sh, input logic fl);
        int waited;
        in_acc   = acc;
        in_bias  = bias;
        in_mult  = mult;
        in_shift = sh;
        in_flush = fl;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: %0d words outstanding, required 0", expQ.size());
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handoff is matched against the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            wordsSeen++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected word: got 0x%08h count %0d, required no word", out_data, out_count);
            end else begin
                logic [34:0] exp;
                exp = expQ.pop_front();
                checkOutput("word data", out_data, exp[31:0]);
                checkOutput("word count", {29'd0, out_count}, {29'd0, exp[34:32]});
            end
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        wordsSeen      = 0;
        reset_n        = 1'b0;
        cfg_we         = 1'b0;
        cfg_out_offset = 32'd0;
        cfg_act_min    = 32'd0;
        cfg_act_max    = 32'd0;
        in_valid       = 1'b0;
        in_acc         = 32'd0;
        in_bias        = 32'd0;
        in_mult        = 32'd0;
        in_shift       = 6'd0;
        in_flush       = 1'b0;
        out_ready      = 1'b1;

        #2;
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset out_data", out_data, 32'd0);
        checkOutput("reset out_count", {29'd0, out_count}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single flushed element, with the accept-to-out_valid latency checked.
        applyConfig(-32'sd128, -32'sd128, 32'sd127);
        pushExpected(32'h00000000, 3'd1);
        applyStimulus(32'd1000, 32'd24, 32'h40000000, 6'h3E, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("latency accept+3 not valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latency accept+4 valid", {31'd0, out_valid}, 32'd1);
        waitDrain();

        // Negative result clamped to act_min.
        applyConfig(32'sd0, -32'sd128, 32'sd127);
        pushExpected(32'h00000080, 3'd1);
        applyStimulus(-32'sd1000, 32'd0, 32'h40000000, 6'h00, 1'b1);
        waitDrain();

        // Rounding of a half in both signs.
        applyConfig(32'sd10, -32'sd128, 32'sd127);
        pushExpected(32'h0000070D, 3'd2);
        applyStimulus(32'd5, 32'd0, 32'h7FFFFFFF, 6'h3F, 1'b0);
        applyStimulus(-32'sd5, 32'd0, 32'h7FFFFFFF, 6'h3F, 1'b1);
        waitDrain();

        // SRDHM saturation corner.
        applyConfig(32'sd0, -32'sd128, 32'sd127);
        pushExpected(32'h0000007F, 3'd1);
        applyStimulus(32'h80000000, 32'd0, 32'h80000000, 6'h00, 1'b1);
        waitDrain();

        // Narrow activation range and a positive shift.
        applyConfig(32'sd0, -32'sd5, 32'sd5);
        pushExpected(32'h000205FB, 3'd3);
        applyStimulus(-32'sd1000, 32'd0, 32'h40000000, 6'h00, 1'b0);
        applyStimulus(32'd3, 32'd0, 32'h40000000, 6'd2, 1'b0);
        applyStimulus(32'd4, 32'd0, 32'h40000000, 6'h00, 1'b1);
        waitDrain();

        // Full words back to back with the consumer refusing the first word for five cycles.
        applyConfig(32'sd0, -32'sd128, 32'sd127);
        pushExpected(32'h04030201, 3'd4);
        pushExpected(32'h08070605, 3'd4);
        pushExpected(32'h0C0B0A09, 3'd4);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 12; i++)
                    applyStimulus(32'(2 * i), 32'd0, 32'h40000000, 6'h00, 1'b0);
            end
            begin
                int waited;
                waited = 0;
                while (!out_valid && waited < 100) begin
                    @(negedge clk);
                    waited++;
                end
                checkOutput("stall word appears", {31'd0, out_valid}, 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
                    checkOutput("stall out_data", out_data, 32'h04030201);
                    checkOutput("stall out_count", {29'd0, out_count}, 32'd4);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with two lanes packed and three elements in flight.
        for (int i = 1; i <= 5; i++)
            applyStimulus(32'(2 * i), 32'd0, 32'h40000000, 6'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midreset out_count", {29'd0, out_count}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        pushExpected(32'h04030201, 3'd4);
        for (int i = 1; i <= 4; i++)
            applyStimulus(32'(2 * i), 32'd0, 32'h40000000, 6'h00, 1'b0);
        waitDrain();

        repeat (4) @(posedge clk);
        checkOutput("total words", 32'(wordsSeen), 32'd9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
